// File: rtl/debounce_bank.sv
// debounce_bank: N-channel switch debouncer.
//
// Each channel passes its raw input through a 2-flop synchroniser, then a
// stability counter accepts a new level only after STABLE_CYCLES consecutive
// TICK-qualified samples that differ from the current debounced level. Any
// sample that agrees with the debounced level restarts qualification.
//
// Ports:
//   CLK      in   1  clock, all state on rising edge
//   AR       in   1  asynchronous active-high reset
//   TICK     in   1  sample-enable strobe (tie high to count every CLK)
//   D        in   N  raw switch inputs, asynchronous to CLK
//   BFC      out  N  debounced levels
//   RISE     out  N  one-cycle pulse when a BFC bit goes 0->1
//   FALL     out  N  one-cycle pulse when a BFC bit goes 1->0
//
// Optional build macro DEBOUNCE_IRQ_EN adds:
//   EVT_CLR  in   N  clears EVT[i] on the next edge
//   EVT      out  N  sticky per-channel event flags (set on RISE/FALL)
//   IRQ      out  1  registered OR of EVT
module debounce_bank #(
    parameter int   N             = 4,
    parameter int   STABLE_CYCLES = 16,
    parameter logic RESET_VAL     = 1'b0,
    localparam int  CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic         CLK,
    input  logic         AR,
    input  logic         TICK,
    input  logic [N-1:0] D,
    output logic [N-1:0] BFC,
    output logic [N-1:0] RISE,
    output logic [N-1:0] FALL
`ifdef DEBOUNCE_IRQ_EN
    ,
    input  logic [N-1:0] EVT_CLR,
    output logic [N-1:0] EVT,
    output logic         IRQ
`endif
);

    if (STABLE_CYCLES < 1) begin : g_bad_cfg
        $error("debounce_bank: STABLE_CYCLES must be >= 1");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [N-1:0]            s1_q, s1_d;
    logic [N-1:0]            s2_q, s2_d;
    logic [N-1:0]            bfc_q, bfc_d;
    logic [N-1:0]            rise_q, rise_d;
    logic [N-1:0]            fall_q, fall_d;
    logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d   = D;
        s2_d   = s1_q;
        bfc_d  = bfc_q;
        cnt_d  = cnt_q;
        rise_d = '0;
        fall_d = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (s2_q[i] == bfc_q[i]) begin
                // Agreement restarts qualification even on non-TICK cycles,
                // so a bounce between strobes is never missed.
                cnt_d[i] = '0;
            end else if (!TICK) begin
                cnt_d[i] = cnt_q[i];
            end else if (cnt_q[i] == CNT_MAX) begin
                bfc_d[i]  = s2_q[i];
                cnt_d[i]  = '0;
                rise_d[i] = s2_q[i];
                fall_d[i] = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge AR) begin
        if (AR) begin
            s1_q   <= {N{RESET_VAL}};
            s2_q   <= {N{RESET_VAL}};
            bfc_q  <= {N{RESET_VAL}};
            cnt_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            bfc_q  <= bfc_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign BFC  = bfc_q;
    assign RISE = rise_q;
    assign FALL = fall_q;

`ifdef DEBOUNCE_IRQ_EN
    logic [N-1:0] evt_q, evt_d;
    logic         irq_q, irq_d;

    always_comb begin
        // Set term is OR-ed after the clear so a coincident event wins.
        evt_d = (evt_q & ~EVT_CLR) | rise_d | fall_d;
        irq_d = |evt_q;
    end

    always_ff @(posedge CLK or posedge AR) begin
        if (AR) begin
            evt_q <= '0;
            irq_q <= 1'b0;
        end else begin
            evt_q <= evt_d;
            irq_q <= irq_d;
        end
    end

    assign EVT = evt_q;
    assign IRQ = irq_q;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: self-checking bench for debounce_bank.
// A vector table covers a clean step and bounce filtering; hand sequences
// cover TICK gating, glitch restart, async reset mid-count and the
// STABLE_CYCLES=1 boundary; a random phase runs against a reference model
// that counts TICK-qualified samples since the last point of agreement.
module tb_debounce_bank;

    localparam int   N  = 4;
    localparam int   S  = 4;
    localparam logic RV = 1'b0;

    logic         CLK  = 1'b0;
    logic         AR   = 1'b0;
    logic         TICK = 1'b0;
    logic [N-1:0] D    = '0;
    logic [N-1:0] BFC, RISE, FALL;

    logic [0:0] d1 = 1'b0;
    logic [0:0] bfc1, rise1, fall1;

`ifdef DEBOUNCE_IRQ_EN
    logic [N-1:0] evt_clr = '0;
    logic [N-1:0] evt;
    logic         irq;
    logic [0:0]   evt_clr1 = 1'b0;
    logic [0:0]   evt1;
    logic         irq1;
`endif

    int total = 0;
    int bad   = 0;

    debounce_bank #(.N(N), .STABLE_CYCLES(S), .RESET_VAL(RV)) u_dut (
        .CLK(CLK), .AR(AR), .TICK(TICK), .D(D),
        .BFC(BFC), .RISE(RISE), .FALL(FALL)
`ifdef DEBOUNCE_IRQ_EN
        , .EVT_CLR(evt_clr), .EVT(evt), .IRQ(irq)
`endif
    );

    debounce_bank #(.N(1), .STABLE_CYCLES(1), .RESET_VAL(1'b0)) u_dut1 (
        .CLK(CLK), .AR(AR), .TICK(TICK), .D(d1),
        .BFC(bfc1), .RISE(rise1), .FALL(fall1)
`ifdef DEBOUNCE_IRQ_EN
        , .EVT_CLR(evt_clr1), .EVT(evt1), .IRQ(irq1)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference model state
    logic [N-1:0] bfc_m, rise_m, fall_m;
    logic [N-1:0] d_hist[$];
    bit           tick_hist[$];
    int           ref_e[N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        bfc_m  = {N{RV}};
        rise_m = '0;
        fall_m = '0;
        d_hist.delete();
        tick_hist.delete();
        for (int i = 0; i < N; i++) ref_e[i] = -1;
    endtask

    // One clock edge of the model. The synchronised sample seen at edge e
    // is the input presented two edges earlier (reset level before that).
    // A channel flips when S TICK edges have elapsed since the last edge at
    // which its sample agreed with the debounced level (or it last flipped).
    task automatic model_edge(input logic [N-1:0] d, input bit t);
        int e;
        int n;
        logic [N-1:0] s2;
        e  = d_hist.size();
        s2 = (e >= 2) ? d_hist[e-2] : {N{RV}};
        d_hist.push_back(d);
        tick_hist.push_back(t);
        rise_m = '0;
        fall_m = '0;
        for (int i = 0; i < N; i++) begin
            if (s2[i] == bfc_m[i]) begin
                ref_e[i] = e;
            end else if (t) begin
                n = 0;
                for (int j = ref_e[i] + 1; j <= e; j++) n += int'(tick_hist[j]);
                if (n == S) begin
                    bfc_m[i]  = s2[i];
                    rise_m[i] = s2[i];
                    fall_m[i] = ~s2[i];
                    ref_e[i]  = e;
                end
            end
        end
    endtask

    task automatic step(input logic [N-1:0] d, input bit t);
        D    = d;
        TICK = t;
        @(posedge CLK);
        model_edge(d, t);
        #1;
        check("model", 32'({BFC, RISE, FALL}), 32'({bfc_m, rise_m, fall_m}));
    endtask

    task automatic do_reset();
        AR = 1'b1;
        #1;
        model_reset();
        check("reset_async", 32'({BFC, RISE, FALL}), 32'({{N{RV}}, {N{1'b0}}, {N{1'b0}}}));
        check("reset_async_s1", 32'({bfc1, rise1, fall1}), 32'd0);
        @(posedge CLK);
        #1;
        check("reset_held", 32'({BFC, RISE, FALL}), 32'({{N{RV}}, {N{1'b0}}, {N{1'b0}}}));
        AR = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] d;
        logic         tick;
        logic [N-1:0] bfc;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [N-1:0] rd;
        int           p;

        tbl[0]  = '{4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0000};
        tbl[6]  = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0011, 1'b1, 4'b0001, 4'b0000, 4'b0000};
        tbl[8]  = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b0011, 1'b1, 4'b0001, 4'b0000, 4'b0000};
        tbl[10] = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000};
        tbl[11] = '{4'b0011, 1'b1, 4'b0001, 4'b0000, 4'b0000};
        tbl[12] = '{4'b0011, 1'b1, 4'b0001, 4'b0000, 4'b0000};
        tbl[13] = '{4'b0011, 1'b1, 4'b0001, 4'b0000, 4'b0000};
        tbl[14] = '{4'b0011, 1'b1, 4'b0001, 4'b0000, 4'b0000};
        tbl[15] = '{4'b0011, 1'b1, 4'b0001, 4'b0000, 4'b0000};
        tbl[16] = '{4'b0011, 1'b1, 4'b0011, 4'b0010, 4'b0000};
        tbl[17] = '{4'b0011, 1'b1, 4'b0011, 4'b0000, 4'b0000};

        model_reset();
        #2;

        // Reset then hold at zero
        do_reset();
        for (int c = 0; c < 50; c++) begin
            step('0, 1'b1);
            check("hold_zero", 32'({BFC, RISE, FALL}), 32'd0);
        end

        // Clean step on ch0, then bounce on ch1
        for (int k = 0; k < 18; k++) begin
            step(tbl[k].d, tbl[k].tick);
            check("tbl_bfc", 32'(BFC), 32'(tbl[k].bfc));
            check("tbl_rise", 32'(RISE), 32'(tbl[k].rise));
            check("tbl_fall", 32'(FALL), 32'(tbl[k].fall));
        end

        // TICK every 3rd cycle: ch2 rises on the 4th tick seeing the new level
        for (int c = 0; c < 16; c++) begin
            step(4'b0111, (c % 3) == 0);
            check("tick_rise_bfc2", 32'(BFC[2]), 32'(c >= 12));
            check("tick_rise_pulse2", 32'(RISE[2]), 32'(c == 12));
        end

        // Falling with a 1-cycle glitch between ticks: count restarts
        for (int c = 0; c < 25; c++) begin
            step((c == 8) ? 4'b0111 : 4'b0011, (c % 3) == 0);
            check("glitch_bfc2", 32'(BFC[2]), 32'(c < 21));
            check("glitch_fall2", 32'(FALL[2]), 32'(c == 21));
        end

        // Async reset mid-count on ch3, then full requalification
        for (int c = 0; c < 3; c++) step(4'b1011, 1'b1);
        do_reset();
        for (int c = 0; c < 10; c++) begin
            d1 = 1'b1;
            step(4'b1011, 1'b1);
            check("requal_bfc", 32'(BFC), 32'((c >= 5) ? 4'b1011 : 4'b0000));
            check("requal_rise", 32'(RISE), 32'((c == 5) ? 4'b1011 : 4'b0000));
            check("s1_bfc", 32'(bfc1), 32'(c >= 2));
            check("s1_rise", 32'(rise1), 32'(c == 2));
        end

        // Randomised traffic against the model
        rd = D;
        p  = 2;
        for (int c = 0; c < 3000; c++) begin
            if ((c % 64) == 0) p = int'($urandom_range(0, 12));
            for (int i = 0; i < N; i++)
                if (int'($urandom_range(0, 63)) < p) rd[i] = ~rd[i];
            if ($urandom_range(0, 599) == 0) do_reset();
            step(rd, $urandom_range(0, 3) != 0);
            check("rise_fall_excl", 32'(RISE & FALL), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
